// File: rtl/regfile_pkg.sv
// Shared CPU constants for the register file and the write-address selector.
package regfile_pkg;

  localparam int         REG_W      = 32;
  localparam int         REG_ADDR_W = 5;
  localparam int         REG_NUM    = 32;
  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam logic [4:0] REG_RA     = 5'd31;

endpackage

// File: rtl/regfile_if.sv
// Register-file access bus: one write port and two combinational read ports.
interface regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;

  modport master (
    output we, waddr, wdata, raddr1, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2,
    output rdata1, rdata2
  );

endinterface

// File: rtl/regfile.sv
// 32 x 32-bit MIPS register file: $0 hardwired to zero, two combinational reads,
// one clocked write, optional same-cycle write-to-read forwarding.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int BYPASS = 0
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  localparam int                DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              hit1;
  logic              hit2;

  // Read mux: reset and $0 force zero, forwarding wins over the stored value.
  function automatic logic [DATA_W-1:0] rd_sel(
    input logic [ADDR_W-1:0] addr,
    input logic              hit,
    input logic [DATA_W-1:0] stored,
    input logic [DATA_W-1:0] fwd,
    input logic              in_rst
  );
    logic [DATA_W-1:0] r;
    if (in_rst || (addr == ZERO_A)) begin
      r = '0;
    end else if (hit) begin
      r = fwd;
    end else begin
      r = stored;
    end
    return r;
  endfunction

  if (BYPASS != 0) begin : g_bypass
    assign hit1 = bus.we && (bus.waddr == bus.raddr1);
    assign hit2 = bus.we && (bus.waddr == bus.raddr2);
  end else begin : g_no_bypass
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if ((i != 0) && bus.we && (bus.waddr == ADDR_W'(i))) begin
        mem_d[i] = bus.wdata;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    bus.rdata1 = rd_sel(bus.raddr1, hit1, mem_q[bus.raddr1], bus.wdata, rst);
    bus.rdata2 = rd_sel(bus.raddr2, hit2, mem_q[bus.raddr2], bus.wdata, rst);
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench: drives a BYPASS=0 and a BYPASS=1 register file in lockstep
// and compares both against an array model of the architectural registers.
module tb_regfile;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic [31:0] model [32];

  regfile_if #(.DATA_W(REG_W), .ADDR_W(REG_ADDR_W)) if_nb ();
  regfile_if #(.DATA_W(REG_W), .ADDR_W(REG_ADDR_W)) if_bp ();

  regfile #(.DATA_W(REG_W), .ADDR_W(REG_ADDR_W), .BYPASS(0)) dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (if_nb.slave)
  );

  regfile #(.DATA_W(REG_W), .ADDR_W(REG_ADDR_W), .BYPASS(1)) dut_bp (
    .clk (clk),
    .rst (rst),
    .bus (if_bp.slave)
  );

  always #5 clk = ~clk;

  // waddr must be known whenever a write is requested
  always @(posedge clk) begin
    if ((if_nb.we === 1'b1) && $isunknown(if_nb.waddr)) begin
      n_fail++;
      $display("FAIL waddr_known: got waddr=%b while we=1, required a known index", if_nb.waddr);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    if_nb.we = we; if_nb.waddr = wa; if_nb.wdata = wd; if_nb.raddr1 = r1; if_nb.raddr2 = r2;
    if_bp.we = we; if_bp.waddr = wa; if_bp.wdata = wd; if_bp.raddr1 = r1; if_bp.raddr2 = r2;
  endtask

  task automatic set_rst(input logic v);
    rst = v;
    if (v) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end
  endtask

  // One rising edge (architectural write applied to the model), returning at the falling edge.
  task automatic edge_clk();
    @(posedge clk);
    if (!rst && (if_nb.we === 1'b1) && (if_nb.waddr != 5'd0)) model[if_nb.waddr] = if_nb.wdata;
    @(negedge clk);
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (rst || (a == 5'd0)) return 32'h0;
    if (byp && (if_nb.we === 1'b1) && (if_nb.waddr == a)) return if_nb.wdata;
    return model[a];
  endfunction

  function automatic logic [127:0] obs();
    return {if_nb.rdata1, if_nb.rdata2, if_bp.rdata1, if_bp.rdata2};
  endfunction

  task automatic test_reset();
    logic [127:0] got;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    #2;
    got = obs(); n_assert++;
    if (got !== 128'h0) begin n_fail++; $display("FAIL reset_read_zero: got %h required %h", got, 128'h0); end
    edge_clk();
    set_rst(1'b0);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    #1;
    got = obs(); n_assert++;
    if (got !== 128'h0) begin n_fail++; $display("FAIL reset_blocks_write: got %h required %h", got, 128'h0); end
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    edge_clk();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    #1;
    got = obs(); n_assert++;
    if (got !== {4{32'hDEADBEEF}}) begin n_fail++; $display("FAIL reset_preload: got %h required %h", got, {4{32'hDEADBEEF}}); end
    #1;
    set_rst(1'b1);
    #1;
    got = obs(); n_assert++;
    if (got !== 128'h0) begin n_fail++; $display("FAIL reset_async_clear: got %h required %h", got, 128'h0); end
    edge_clk();
    set_rst(1'b0);
    #1;
    got = obs(); n_assert++;
    if (got !== 128'h0) begin n_fail++; $display("FAIL reset_contents_lost: got %h required %h", got, 128'h0); end
  endtask

  task automatic test_basic();
    logic [127:0] got;
    drive(1'b1, 5'd8, 32'h12345678, 5'd0, 5'd0);
    edge_clk();
    drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd8);
    #1;
    got = obs(); n_assert++;
    if (got !== {4{32'h12345678}}) begin n_fail++; $display("FAIL basic_rw: got %h required %h", got, {4{32'h12345678}}); end
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd9);
    #1;
    got = obs(); n_assert++;
    if (got !== 128'h0) begin n_fail++; $display("FAIL basic_neighbours: got %h required %h", got, 128'h0); end
  endtask

  task automatic test_zero();
    logic [127:0] got;
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #1;
    got = obs(); n_assert++;
    if (got !== 128'h0) begin n_fail++; $display("FAIL zero_pre_edge: got %h required %h", got, 128'h0); end
    edge_clk();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    got = obs(); n_assert++;
    if (got !== 128'h0) begin n_fail++; $display("FAIL zero_post_edge: got %h required %h", got, 128'h0); end
  endtask

  task automatic test_we_gating();
    logic [127:0] got;
    drive(1'b1, 5'd9, 32'hA5A5A5A5, 5'd0, 5'd0);
    edge_clk();
    drive(1'b0, 5'd9, 32'h00000001, 5'd9, 5'd9);
    repeat (3) edge_clk();
    #1;
    got = obs(); n_assert++;
    if (got !== {4{32'hA5A5A5A5}}) begin n_fail++; $display("FAIL we_gating: got %h required %h", got, {4{32'hA5A5A5A5}}); end
  endtask

  task automatic test_read_during_write();
    logic [127:0] got;
    drive(1'b1, 5'd3, 32'h00000011, 5'd0, 5'd0);
    edge_clk();
    drive(1'b1, 5'd3, 32'h00000022, 5'd0, 5'd3);
    #1;
    got = obs(); n_assert++;
    if (got !== {32'h0, 32'h11, 32'h0, 32'h22}) begin
      n_fail++; $display("FAIL rdw_pre_edge: got %h required %h", got, {32'h0, 32'h11, 32'h0, 32'h22});
    end
    edge_clk();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    #1;
    got = obs(); n_assert++;
    if (got !== {4{32'h22}}) begin n_fail++; $display("FAIL rdw_post_edge: got %h required %h", got, {4{32'h22}}); end
  endtask

  task automatic test_link_sweep();
    logic [127:0] got;
    logic [31:0]  e1;
    logic [31:0]  e2;
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), (5'(i) == REG_RA) ? 32'h00400004 : 32'(i) * 32'h01010101, 5'd0, 5'd0);
      edge_clk();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      #1;
      e1 = (i == 0) ? 32'h0 : (i == 31) ? 32'h00400004 : 32'(i) * 32'h01010101;
      e2 = (i == 31) ? 32'h0 : (i == 0) ? 32'h00400004 : 32'(31 - i) * 32'h01010101;
      got = obs(); n_assert++;
      if (got !== {e1, e2, e1, e2}) begin
        n_fail++; $display("FAIL sweep_r%0d: got %h required %h", i, got, {e1, e2, e1, e2});
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] got;
    logic [127:0] exp;
    logic [4:0]   wa;
    logic [4:0]   r1;
    logic [4:0]   r2;
    bit           pulse;
    for (int n = 0; n < 300; n++) begin
      pulse = ($urandom_range(0, 39) == 0);
      if (pulse) set_rst(1'b1);
      wa = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wa, $urandom, r1, r2);
      #1;
      exp = {exp_rd(r1, 1'b0), exp_rd(r2, 1'b0), exp_rd(r1, 1'b1), exp_rd(r2, 1'b1)};
      got = obs(); n_assert++;
      if (got !== exp) begin n_fail++; $display("FAIL random_%0d: got %h required %h", n, got, exp); end
      edge_clk();
      if (pulse) set_rst(1'b0);
    end
  endtask

  initial begin
    set_rst(1'b1);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    test_reset();
    test_basic();
    test_zero();
    test_we_gating();
    test_read_during_write();
    test_link_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle MIPS core.
- Sits directly downstream of the write-register-address selector; its 5-bit output (rt, rd, or 31 for jal/link) drives this block's `waddr`.
- Provides two combinational read ports (rs, rt) and one clocked write port. Register $0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W = 32
- BYPASS, 0, 1 = a read of the address being written this cycle returns `wdata`; 0 = it returns the stored value

Ports:
- clk  input  1  core clock; writes occur on the rising edge
- rst  input  1  reset, asynchronous, active-high; clears all registers
- we  input  1  write enable from the control unit
- waddr  input  ADDR_W  write register index (from the write-address selector)
- wdata  input  DATA_W  write data (ALU result, memory data, or PC+4 for link)
- raddr1  input  ADDR_W  read port 1 index (rs)
- raddr2  input  ADDR_W  read port 2 index (rt)
- rdata1  output  DATA_W  read port 1 data
- rdata2  output  DATA_W  read port 2 data

Behaviour:
- Storage: 32 entries of DATA_W bits. Entry 0 is never written; it always reads 32'h0.
- Reset:
  - `rst` high clears entries 1..31 to 0 immediately, without waiting for `clk`.
  - While `rst` is high, writes are blocked and `rdata1`/`rdata2` read 0 for every address.
  - Deasserting `rst` resumes normal writes at the next rising edge.
  - A `rst` pulse arriving mid-program discards all register contents. There is no partial preservation.
- Write:
  - At posedge `clk`, if `rst` is low, `we` is 1 and `waddr` is not 0, then entry[waddr] <= wdata.
  - If `we` is 0 or `waddr` is 0, there is no state change. A write to $0 is silently dropped.
- Read:
  - Purely combinational, zero-cycle latency: `rdataN` = entry[raddrN], or 0 when raddrN = 0.
  - Both ports are independent. raddr1 = raddr2 is legal and both return the same value.
- Read-during-write (raddrN = waddr != 0, `we` = 1, same cycle):
  - BYPASS=0: `rdataN` shows the old value until the edge, then the new value. This is the required mode for the single-cycle core.
  - BYPASS=1: `rdataN` = `wdata` combinationally before the edge.
  - raddrN = 0 always reads 0, even with BYPASS=1 and waddr = 0.
- Link write: waddr = 31 with wdata = PC+4 is a normal write. There is no special handling.
- Unknown inputs: X on `waddr` with `we` = 1 is a usage error. The bench asserts that `waddr` is never X/Z when `we` = 1.
- No other outputs and no stall or handshake. The write completes in exactly one cycle.

Decomposition:
- Shared CPU package:
  - REG_W = 32
  - REG_ADDR_W = 5
  - REG_NUM = 32
  - REG_ZERO = 5'd0
  - REG_RA = 5'd31 (shared with the write-address selector's link constant)
- No sub-module is needed. The two read ports are identical inline logic, and the BYPASS path is a generate branch.

Test Plan:
- Reset clear: write 32'hDEADBEEF to $5, then pulse `rst` between clock edges → `rdata1` (raddr1 = 5) is 0 immediately, before the next edge.
- Basic write/read: `we` = 1, waddr = 8, wdata = 32'h12345678, one edge → raddr1 = 8 and raddr2 = 8 both return 32'h12345678. Other registers stay 0.
- $0 protection: `we` = 1, waddr = 0, wdata = 32'hFFFFFFFF, one edge → raddr1 = 0 returns 0, with both BYPASS=0 and BYPASS=1.
- Write-enable gating: preload $9 = 32'hA5A5A5A5, then `we` = 0, waddr = 9, wdata = 32'h1 across 3 edges → $9 still reads 32'hA5A5A5A5.
- Read-during-write: $3 = 32'h11, `we` = 1, waddr = 3, wdata = 32'h22, raddr2 = 3 sampled before the edge → 32'h11 with BYPASS=0, 32'h22 with BYPASS=1. After the edge, both modes read 32'h22.
- Link + sweep: write (i * 32'h01010101) to each register 1..31 with waddr = 31 last (wdata = 32'h00400004) → the readback sweep of all 32 registers on both ports matches, with $31 = 32'h00400004 and $0 = 0.
